sys_array: RTL and testbench

//   Keypad-driven 2x2 systolic matrix multiplier with a 4-digit 7-segment display.
//   The user enters single-digit matrices A and B from a 4x4 keypad, then starts the run.
//   An output-stationary 2x2 PE array computes C = A x B.
//   One C element is shown per screen in decimal, together with its index.

---
 rtl/sysarray_pkg.sv | 37 +++
 rtl/sysarray_pe.sv | 32 +++
 rtl/sys_array.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sys_array.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarray_pkg.sv
// Shared constants for the keypad-driven 2x2 systolic multiplier: widths, FSM states,
// keypad codes and the 7-segment digit table.
package sysarray_pkg;

    localparam int DW   = 4;
    localparam int ACCW = 8;
    localparam int N    = 2;

    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Digit keys use their own value 0..9 as the code.
    localparam logic [3:0] KEY_GO   = 4'd10;
    localparam logic [3:0] KEY_NEXT = 4'd11;
    localparam logic [3:0] KEY_CLR  = 4'd12;
    localparam logic [3:0] KEY_NONE = 4'd15;

    localparam logic [2:0] RUN_LAST = 3'd4;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h3F;
            4'd1:    seg_digit = 7'h06;
            4'd2:    seg_digit = 7'h5B;
            4'd3:    seg_digit = 7'h4F;
            4'd4:    seg_digit = 7'h66;
            4'd5:    seg_digit = 7'h6D;
            4'd6:    seg_digit = 7'h7D;
            4'd7:    seg_digit = 7'h07;
            4'd8:    seg_digit = 7'h7F;
            4'd9:    seg_digit = 7'h6F;
            default: seg_digit = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/sysarray_pe.sv
// Output-stationary processing element: forwards a right and b down through registers
// and accumulates a*b while enabled.
module sysarray_pe
    import sysarray_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [ACCW-1:0] acc
);

    logic [2*DW-1:0] prod;

    assign prod = a_in * b_in;

    always_ff @(posedge clk) begin
        if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/sys_array.sv
// Keypad entry of 2x2 digit matrices A and B, systolic C = A x B, and a 4-digit display.
// Build option: SYSARRAY_SEG_ACTIVE_LOW_EN inverts all segment outputs (common anode).
module sys_array
    import sysarray_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       conf,
    input  logic [3:0] rin,
    input  logic [3:0] cin,
    output logic [6:0] segout0,
    output logic [6:0] segout1,
    output logic [6:0] segout2,
    output logic [6:0] segout3,
    output logic       on,
    output logic       start
);

`ifdef SYSARRAY_SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_MASK = 7'h7F;
`else
    localparam logic [6:0] SEG_MASK = 7'h00;
`endif

    logic [1:0]      state;
    logic [2:0]      cnt;
    logic [1:0]      ptr_a, ptr_b, idx;
    logic            sel;
    logic            key_prev;
    logic [DW-1:0]   mat_a [4];
    logic [DW-1:0]   mat_b [4];

    logic [1:0]      row, col;
    logic [3:0]      key_code;
    logic            key_valid, key_evt, live;
    logic            digit_evt, go_evt, next_evt, clr_evt;
    logic            pe_clr, pe_en;

    always_comb begin
        row = '0;
        col = '0;
        for (int k = 0; k < 4; k++) begin
            if (rin[k]) row = 2'(k);
            if (cin[k]) col = 2'(k);
        end
        case ({row, col})
            4'b0000: key_code = 4'd1;
            4'b0001: key_code = 4'd2;
            4'b0010: key_code = 4'd3;
            4'b0011: key_code = 4'd4;
            4'b0100: key_code = 4'd5;
            4'b0101: key_code = 4'd6;
            4'b0110: key_code = 4'd7;
            4'b0111: key_code = 4'd8;
            4'b1000: key_code = 4'd9;
            4'b1001: key_code = 4'd0;
            4'b1010: key_code = KEY_GO;
            4'b1011: key_code = KEY_NEXT;
            4'b1100: key_code = KEY_CLR;
            default: key_code = KEY_NONE;
        endcase
    end

    // Event fires on the first cycle a valid key appears; holding it produces nothing more.
    assign key_valid = $onehot(rin) && $onehot(cin);
    assign key_evt   = key_valid && !key_prev;
    assign live      = (state != ST_RUN);
    assign digit_evt = key_evt && live && (key_code <= 4'd9);
    assign go_evt    = key_evt && live && (key_code == KEY_GO);
    assign next_evt  = key_evt && live && (key_code == KEY_NEXT);
    assign clr_evt   = key_evt && live && (key_code == KEY_CLR);
    assign pe_clr    = rst || go_evt;
    assign pe_en     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) key_prev <= 1'b0;
        else     key_prev <= key_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mat_a[k] <= '0;
                mat_b[k] <= '0;
            end
            ptr_a <= '0;
            ptr_b <= '0;
            sel   <= 1'b0;
        end else if (digit_evt) begin
            sel <= conf;
            if (conf) begin
                mat_b[ptr_b] <= key_code;
                ptr_b        <= ptr_b + 2'd1;
            end else begin
                mat_a[ptr_a] <= key_code;
                ptr_a        <= ptr_a + 2'd1;
            end
        end else if (clr_evt) begin
            sel <= conf;
            // CLR from the result screen only leaves SHOW; the matrices survive.
            if (state == ST_ENTRY) begin
                if (conf) begin
                    for (int k = 0; k < 4; k++) mat_b[k] <= '0;
                    ptr_b <= '0;
                end else begin
                    for (int k = 0; k < 4; k++) mat_a[k] <= '0;
                    ptr_a <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ENTRY;
            cnt   <= '0;
            idx   <= '0;
            on    <= 1'b0;
            start <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (go_evt) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        on    <= 1'b1;
                        start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt == RUN_LAST) begin
                        state <= ST_SHOW;
                        idx   <= '0;
                        on    <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_SHOW: begin
                    if (go_evt) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        on    <= 1'b1;
                        start <= 1'b1;
                    end else if (next_evt) begin
                        idx <= idx + 2'd1;
                    end else if (digit_evt || clr_evt) begin
                        state <= ST_ENTRY;
                    end
                end
                default: begin
                    state <= ST_ENTRY;
                    on    <= 1'b0;
                end
            endcase
        end
    end

    // Skewed feed: row i carries A[i][t-i], column j carries B[t-j][j], zero outside range.
    logic [DW-1:0] feed_a [N];
    logic [DW-1:0] feed_b [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            feed_a[k] = '0;
            feed_b[k] = '0;
        end
        if (state == ST_RUN) begin
            case (cnt)
                3'd0: begin
                    feed_a[0] = mat_a[0];
                    feed_b[0] = mat_b[0];
                end
                3'd1: begin
                    feed_a[0] = mat_a[1];
                    feed_a[1] = mat_a[2];
                    feed_b[0] = mat_b[2];
                    feed_b[1] = mat_b[1];
                end
                3'd2: begin
                    feed_a[1] = mat_a[3];
                    feed_b[1] = mat_b[3];
                end
                default: ;
            endcase
        end
    end

    logic [DW-1:0]   a_h   [N][N];
    logic [DW-1:0]   b_h   [N][N];
    logic [ACCW-1:0] acc_h [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] a_src, b_src;
            if (j == 0) begin : g_a_edge
                assign a_src = feed_a[i];
            end else begin : g_a_link
                assign a_src = a_h[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_src = feed_b[j];
            end else begin : g_b_link
                assign b_src = b_h[i-1][j];
            end
            sysarray_pe u_pe (
                .clk   (clk),
                .clr   (pe_clr),
                .en    (pe_en),
                .a_in  (a_src),
                .b_in  (b_src),
                .a_out (a_h[i][j]),
                .b_out (b_h[i][j]),
                .acc   (acc_h[i][j])
            );
        end
    end

    logic [ACCW-1:0] c_sel, rem;
    logic [3:0]      hund, tens, units;
    logic [6:0]      d3, d2, d1, d0;

    always_comb begin
        c_sel = acc_h[idx[1]][idx[0]];
        hund  = 4'(c_sel / ACCW'(100));
        rem   = c_sel % ACCW'(100);
        tens  = 4'(rem / ACCW'(10));
        units = 4'(rem % ACCW'(10));
    end

    always_comb begin
        if (state == ST_SHOW) begin
            d3 = seg_digit({2'b00, idx});
            d2 = seg_digit(hund);
            d1 = seg_digit(tens);
            d0 = seg_digit(units);
        end else if (sel) begin
            d3 = seg_digit(mat_b[0]);
            d2 = seg_digit(mat_b[1]);
            d1 = seg_digit(mat_b[2]);
            d0 = seg_digit(mat_b[3]);
        end else begin
            d3 = seg_digit(mat_a[0]);
            d2 = seg_digit(mat_a[1]);
            d1 = seg_digit(mat_a[2]);
            d0 = seg_digit(mat_a[3]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segout3 <= 7'h3F ^ SEG_MASK;
            segout2 <= 7'h3F ^ SEG_MASK;
            segout1 <= 7'h3F ^ SEG_MASK;
            segout0 <= 7'h3F ^ SEG_MASK;
        end else begin
            segout3 <= d3 ^ SEG_MASK;
            segout2 <= d2 ^ SEG_MASK;
            segout1 <= d1 ^ SEG_MASK;
            segout0 <= d0 ^ SEG_MASK;
        end
    end

endmodule

// File: tb/tb_sys_array.sv
// Randomized bench for sys_array against a matrix-level model of the keypad calculator.
module tb_sys_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       conf = 1'b0;
    logic [3:0] rin = '0;
    logic [3:0] cin = '0;
    logic [6:0] segout0, segout1, segout2, segout3;
    logic       on, start;

    sys_array dut (
        .clk     (clk),
        .rst     (rst),
        .conf    (conf),
        .rin     (rin),
        .cin     (cin),
        .segout0 (segout0),
        .segout1 (segout1),
        .segout2 (segout2),
        .segout3 (segout3),
        .on      (on),
        .start   (start)
    );

    always #5 clk = ~clk;

    localparam int K_GO = 10, K_NEXT = 11, K_CLR = 12;

    int n_checks = 0;
    int n_fail   = 0;

    int ma [4];
    int mb [4];
    int mc [4];
    int pa, pb, idx, sel, show;
    logic [6:0] seg_tab [10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_exp(input int d);
        logic [6:0] s;
        s = seg_tab[d];
`ifdef SYSARRAY_SEG_ACTIVE_LOW_EN
        return ~s;
`else
        return s;
`endif
    endfunction

    function automatic logic [27:0] disp_exp();
        int v;
        if (show != 0) begin
            v = mc[idx];
            return {seg_exp(idx), seg_exp(v / 100), seg_exp((v / 10) % 10), seg_exp(v % 10)};
        end else if (sel != 0) begin
            return {seg_exp(mb[0]), seg_exp(mb[1]), seg_exp(mb[2]), seg_exp(mb[3])};
        end
        return {seg_exp(ma[0]), seg_exp(ma[1]), seg_exp(ma[2]), seg_exp(ma[3])};
    endfunction

    task automatic check_disp(input string tag);
        check_eq(tag, {4'b0, segout3, segout2, segout1, segout0}, {4'b0, disp_exp()});
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            ma[k] = 0;
            mb[k] = 0;
            mc[k] = 0;
        end
        pa = 0; pb = 0; idx = 0; sel = 0; show = 0;
    endfunction

    function automatic void model_key(input int code, input int c);
        if (code == K_NEXT) begin
            if (show != 0) idx = (idx + 1) % 4;
        end else if (code <= 9) begin
            show = 0;
            sel  = c;
            if (c != 0) begin mb[pb] = code; pb = (pb + 1) % 4; end
            else        begin ma[pa] = code; pa = (pa + 1) % 4; end
        end else if (code == K_CLR) begin
            sel = c;
            if (show == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (c != 0) mb[k] = 0;
                    else        ma[k] = 0;
                end
                if (c != 0) pb = 0;
                else        pa = 0;
            end
            show = 0;
        end
    endfunction

    // C[i][j] = sum_k A[i][k]*B[k][j]; element index is row-major.
    function automatic void model_run();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mc[i*2+j] = ma[i*2] * mb[j] + ma[i*2+1] * mb[2+j];
        show = 1;
        idx  = 0;
    endfunction

    function automatic logic [7:0] key_lines(input int code);
        int r, c;
        if (code >= 1 && code <= 8) begin
            r = (code - 1) / 4;
            c = (code - 1) % 4;
        end else begin
            case (code)
                9:       begin r = 2; c = 0; end
                0:       begin r = 2; c = 1; end
                K_GO:    begin r = 2; c = 2; end
                K_NEXT:  begin r = 2; c = 3; end
                default: begin r = 3; c = 0; end
            endcase
        end
        return {4'(1 << r), 4'(1 << c)};
    endfunction

    task automatic drive_lines(input logic [3:0] r, input logic [3:0] c, input int hold);
        @(negedge clk);
        rin = r;
        cin = c;
        repeat (hold) @(negedge clk);
        rin = '0;
        cin = '0;
        @(negedge clk);
    endtask

    task automatic press(input int code, input int hold);
        logic [7:0] l;
        l = key_lines(code);
        drive_lines(l[7:4], l[3:0], hold);
        model_key(code, int'(conf));
    endtask

    task automatic run_go(input string tag);
        logic [7:0] l;
        int on_n, st_n;
        logic first_start;
        l = key_lines(K_GO);
        on_n = 0; st_n = 0; first_start = 1'b0;
        @(negedge clk);
        rin = l[7:4];
        cin = l[3:0];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (on) on_n++;
            if (start) st_n++;
            if (k == 0) begin
                first_start = start;
                rin = '0;
                cin = '0;
            end
        end
        check_eq({tag, "_on_len"}, on_n, 5);
        check_eq({tag, "_start_cnt"}, st_n, 1);
        check_eq({tag, "_start_first"}, {31'b0, first_start}, 1);
        model_run();
        check_disp({tag, "_c0"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] l;
        int r;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        model_reset();

        repeat (3) @(negedge clk);
        check_disp("reset_segs");
        check_eq("reset_on", {31'b0, on}, 0);
        check_eq("reset_start", {31'b0, start}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_disp("idle_segs");

        conf = 1'b0;
        for (int d = 1; d <= 4; d++) begin
            press(d, 1);
            check_disp($sformatf("enter_a_%0d", d));
        end
        conf = 1'b1;
        for (int d = 5; d <= 8; d++) begin
            press(d, 1);
            check_disp($sformatf("enter_b_%0d", d));
        end
        run_go("go_dir");
        for (int k = 1; k <= 4; k++) begin
            press(K_NEXT, 1);
            check_disp($sformatf("next_%0d", k));
        end

        drive_lines(4'b0011, 4'b0001, 2);
        check_disp("invalid_two_rows");
        drive_lines(4'b1000, 4'b0010, 1);
        check_disp("ignored_r3c1");
        conf = 1'b0;
        press(9, 12);
        check_disp("held_digit");
        press(7, 1);
        check_disp("after_held");

        l = key_lines(K_GO);
        @(negedge clk);
        rin = l[7:4];
        cin = l[3:0];
        @(negedge clk);
        rin = '0;
        cin = '0;
        @(negedge clk);
        check_eq("midrun_on", {31'b0, on}, 1);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_eq("rst_run_on", {31'b0, on}, 0);
        check_eq("rst_run_start", {31'b0, start}, 0);
        check_disp("rst_run_segs");
        rst = 1'b0;
        @(negedge clk);
        check_disp("rst_run_idle");

        for (int it = 0; it < 80; it++) begin
            conf = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 19);
            if (r <= 9)       press(r, $urandom_range(1, 3));
            else if (r == 10) run_go($sformatf("go_rand%0d", it));
            else if (r <= 13) press(K_NEXT, 1);
            else if (r == 14) press(K_CLR, $urandom_range(1, 2));
            else if (r == 15) drive_lines(4'b0101, 4'(1 << $urandom_range(0, 3)), 1);
            else              press($urandom_range(0, 9), 1);
            check_disp($sformatf("rand_%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
